// File: rtl/quadrant_mapper.sv
// Quadrant mapper: pairs queued quadrant tags with in-order trig core results and unfolds sin/cos to the full circle.
// Latency: one cycle from result accept to registered output (full throughput when accept and drain coincide).
// Backpressure: tag_ready drops when the tag FIFO is full; res_ready drops when the FIFO is empty or the output is stalled.

// Small synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module quadrant_mapper_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_dat_o,
   output logic [PTR_W:0]   count_o
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Guard against overflow/underflow; a pop never frees space for a same-cycle push.
   assign do_push = push_i && (count_q != FULL_CNT);
   assign do_pop  = pop_i && (count_q != '0);

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

   // Head entry is read straight from storage, so a fresh push is never visible the same cycle.
   assign pop_dat_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

endmodule

module quadrant_mapper #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int PTR_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tag_valid,
   input  logic [1:0]            tag_quadrant,
   output logic                  tag_ready,
   input  logic                  res_valid,
   input  logic [DATA_WIDTH-1:0] res_sin,
   input  logic [DATA_WIDTH-1:0] res_cos,
   output logic                  res_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_sin,
   output logic [DATA_WIDTH-1:0] out_cos,
   output logic [1:0]            out_quadrant,
   input  logic                  out_ready,
   output logic [PTR_W:0]        tag_count,
   output logic                  orphan_err
);

   localparam logic [PTR_W:0]        FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   // Two's-complement negate that clamps the single unrepresentable case.
   function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
      if (x == MOST_NEG) begin
         return MOST_POS;
      end
      return (~x) + DATA_WIDTH'(1);
   endfunction

   logic [PTR_W:0]        fifo_count;
   logic [1:0]            head_quad;
   logic                  tag_push;
   logic                  res_acc;

   logic [DATA_WIDTH-1:0] map_sin;
   logic [DATA_WIDTH-1:0] map_cos;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_sin_q, out_sin_d;
   logic [DATA_WIDTH-1:0] out_cos_q, out_cos_d;
   logic [1:0]            out_quad_q, out_quad_d;
   logic                  orphan_q, orphan_d;

   // Handshakes are derived from registered state only (plus out_ready for the output slot).
   assign tag_ready = (fifo_count != FULL_CNT);
   assign tag_push  = tag_valid && tag_ready;
   assign res_ready = (fifo_count != '0) && (!out_valid_q || out_ready);
   assign res_acc   = res_valid && res_ready;

   quadrant_mapper_fifo #(
      .WIDTH (2),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (tag_push),
      .push_dat_i (tag_quadrant),
      .pop_i      (res_acc),
      .pop_dat_o  (head_quad),
      .count_o    (fifo_count)
   );

   // Rotate the first-quadrant result by the head tag's quadrant.
   always_comb begin
      map_sin = res_sin;
      map_cos = res_cos;
      case (head_quad)
         2'd0: begin
            map_sin = res_sin;
            map_cos = res_cos;
         end
         2'd1: begin
            map_sin = res_cos;
            map_cos = neg_sat(res_sin);
         end
         2'd2: begin
            map_sin = neg_sat(res_sin);
            map_cos = neg_sat(res_cos);
         end
         default: begin
            map_sin = neg_sat(res_cos);
            map_cos = res_sin;
         end
      endcase
   end

   // Output slot: load on accept, hold while stalled, empty once drained without a refill.
   always_comb begin
      out_valid_d = out_valid_q;
      out_sin_d   = out_sin_q;
      out_cos_d   = out_cos_q;
      out_quad_d  = out_quad_q;
      if (res_acc) begin
         out_valid_d = 1'b1;
         out_sin_d   = map_sin;
         out_cos_d   = map_cos;
         out_quad_d  = head_quad;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Sticky flag for a result arriving with no tag to pair it with.
   always_comb begin
      orphan_d = orphan_q;
      if (res_valid && (fifo_count == '0)) begin
         orphan_d = 1'b1;
      end
   end

   // Output and error registers; reset also discards any held result.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_sin_q   <= '0;
         out_cos_q   <= '0;
         out_quad_q  <= 2'd0;
         orphan_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sin_q   <= out_sin_d;
         out_cos_q   <= out_cos_d;
         out_quad_q  <= out_quad_d;
         orphan_q    <= orphan_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_sin      = out_sin_q;
   assign out_cos      = out_cos_q;
   assign out_quadrant = out_quad_q;
   assign tag_count    = fifo_count;
   assign orphan_err   = orphan_q;

endmodule

// File: tb/tb_quadrant_mapper.sv
// Directed bench for quadrant_mapper: reset, quadrant mapping, saturation, full/wrap, backpressure, orphan.
// Inputs change 1ns after the rising edge; checks are taken at that same point or 1ns later.
// Output side is driven with out_ready as each step requires.
module tb_quadrant_mapper;

   logic        clk = 1'b0;
   logic        reset;
   logic        tag_valid;
   logic [1:0]  tag_quadrant;
   logic        tag_ready;
   logic        res_valid;
   logic [31:0] res_sin;
   logic [31:0] res_cos;
   logic        res_ready;
   logic        out_valid;
   logic [31:0] out_sin;
   logic [31:0] out_cos;
   logic [1:0]  out_quadrant;
   logic        out_ready;
   logic [2:0]  tag_count;
   logic        orphan_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_sin [4];
   logic [31:0] exp_cos [4];

   quadrant_mapper #(
      .DATA_WIDTH (32),
      .DEPTH      (4),
      .PTR_W      (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .tag_valid    (tag_valid),
      .tag_quadrant (tag_quadrant),
      .tag_ready    (tag_ready),
      .res_valid    (res_valid),
      .res_sin      (res_sin),
      .res_cos      (res_cos),
      .res_ready    (res_ready),
      .out_valid    (out_valid),
      .out_sin      (out_sin),
      .out_cos      (out_cos),
      .out_quadrant (out_quadrant),
      .out_ready    (out_ready),
      .tag_count    (tag_count),
      .orphan_err   (orphan_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic chk_out(input string tag, input int q);
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".quad"},  32'(out_quadrant), 32'(q));
      chk({tag, ".sin"},   out_sin, exp_sin[q]);
      chk({tag, ".cos"},   out_cos, exp_cos[q]);
   endtask

   initial begin
      // Hand-computed expectations for s=0x20000000, c=0x376CF5D1.
      exp_sin[0] = 32'h20000000; exp_cos[0] = 32'h376CF5D1;
      exp_sin[1] = 32'h376CF5D1; exp_cos[1] = 32'hE0000000;
      exp_sin[2] = 32'hE0000000; exp_cos[2] = 32'hC8930A2F;
      exp_sin[3] = 32'hC8930A2F; exp_cos[3] = 32'h20000000;

      // Reset held two cycles with traffic offered on both inputs.
      reset = 1'b1; tag_valid = 1'b1; tag_quadrant = 2'd1;
      res_valid = 1'b1; res_sin = 32'h11111111; res_cos = 32'h22222222; out_ready = 1'b1;
      tick(); tick();
      chk("rst.count",  32'(tag_count), 32'd0);
      chk("rst.valid",  32'(out_valid), 32'd0);
      chk("rst.sin",    out_sin, 32'd0);
      chk("rst.cos",    out_cos, 32'd0);
      chk("rst.quad",   32'(out_quadrant), 32'd0);
      chk("rst.orphan", 32'(orphan_err), 32'd0);
      reset = 1'b0; tag_valid = 1'b0; res_valid = 1'b0;
      #1;
      chk("rst.tag_ready", 32'(tag_ready), 32'd1);
      chk("rst.res_ready", 32'(res_ready), 32'd0);

      // Quadrant map: four tags, then four results back to back.
      for (int q = 0; q < 4; q++) begin
         tag_valid = 1'b1; tag_quadrant = 2'(q);
         tick();
      end
      tag_valid = 1'b0;
      chk("map.count_full", 32'(tag_count), 32'd4);
      chk("map.tag_ready",  32'(tag_ready), 32'd0);
      res_valid = 1'b1; res_sin = 32'h20000000; res_cos = 32'h376CF5D1;
      #1;
      chk("map.res_ready",   32'(res_ready), 32'd1);
      chk("map.pre_valid",   32'(out_valid), 32'd0);
      for (int q = 0; q < 4; q++) begin
         tick();
         chk_out("map", q);
      end
      res_valid = 1'b0;
      chk("map.count_empty", 32'(tag_count), 32'd0);
      tick();
      chk("map.drained", 32'(out_valid), 32'd0);

      // Saturating negate of the most negative input.
      tag_valid = 1'b1; tag_quadrant = 2'd2;
      tick();
      tag_valid = 1'b0;
      res_valid = 1'b1; res_sin = 32'h80000000; res_cos = 32'h00000000;
      tick();
      res_valid = 1'b0;
      chk("sat.valid", 32'(out_valid), 32'd1);
      chk("sat.quad",  32'(out_quadrant), 32'd2);
      chk("sat.sin",   out_sin, 32'h7FFFFFFF);
      chk("sat.cos",   out_cos, 32'h00000000);
      tick();

      // Full and wrap: ten tags with quadrants k%4; pointers start at 1 here.
      res_sin = 32'h20000000; res_cos = 32'h376CF5D1;
      for (int k = 0; k < 4; k++) begin
         tag_valid = 1'b1; tag_quadrant = 2'(k % 4);
         tick();
      end
      chk("full.count", 32'(tag_count), 32'd4);
      chk("full.ready", 32'(tag_ready), 32'd0);
      tag_valid = 1'b1; tag_quadrant = 2'd0;
      tick();
      chk("full.held_off", 32'(tag_count), 32'd4);
      res_valid = 1'b1;
      #1;
      chk("full.res_ready", 32'(res_ready), 32'd1);
      tick();
      chk_out("full.pop0", 0);
      chk("full.no_push_when_full", 32'(tag_count), 32'd3);
      for (int k = 4; k < 10; k++) begin
         tag_valid = 1'b1; tag_quadrant = 2'(k % 4);
         tick();
         chk_out("wrap.pp", (k - 3) % 4);
         chk("wrap.count_same", 32'(tag_count), 32'd3);
      end
      tag_valid = 1'b0;
      for (int j = 7; j < 10; j++) begin
         tick();
         chk_out("wrap.tail", j % 4);
         chk("wrap.count", 32'(tag_count), 32'(9 - j));
      end
      res_valid = 1'b0;
      tick();
      chk("wrap.drained", 32'(out_valid), 32'd0);

      // Backpressure: two results pending, output stalled, then released.
      tag_valid = 1'b1; tag_quadrant = 2'd1;
      tick();
      tag_quadrant = 2'd3;
      tick();
      tag_valid = 1'b0; out_ready = 1'b0; res_valid = 1'b1;
      tick();
      chk_out("bp.first", 1);
      #1;
      chk("bp.res_ready_stall", 32'(res_ready), 32'd0);
      tick(); tick();
      chk_out("bp.hold", 1);
      chk("bp.count_hold", 32'(tag_count), 32'd1);
      out_ready = 1'b1;
      #1;
      chk("bp.res_ready_go", 32'(res_ready), 32'd1);
      tick();
      chk_out("bp.second", 3);
      chk("bp.count_zero", 32'(tag_count), 32'd0);
      res_valid = 1'b0;
      tick();
      chk("bp.no_dup", 32'(out_valid), 32'd0);

      // Orphan: result with empty FIFO is refused and flagged stickily.
      res_valid = 1'b1;
      #1;
      chk("orph.res_ready", 32'(res_ready), 32'd0);
      tick();
      res_valid = 1'b0;
      chk("orph.flag",  32'(orphan_err), 32'd1);
      chk("orph.valid", 32'(out_valid), 32'd0);
      chk("orph.count", 32'(tag_count), 32'd0);
      tag_valid = 1'b1; tag_quadrant = 2'd0;
      tick();
      tag_valid = 1'b0; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk_out("orph.traffic", 0);
      chk("orph.sticky", 32'(orphan_err), 32'd1);

      // Reset mid-operation with a queued tag and a stalled output.
      tag_valid = 1'b1; tag_quadrant = 2'd2;
      tick(); tick();
      tag_valid = 1'b0; out_ready = 1'b0; res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
      chk("mid.count_before", 32'(tag_count), 32'd1);
      chk_out("mid.held", 2);
      reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b1;
      chk("mid.count",  32'(tag_count), 32'd0);
      chk("mid.valid",  32'(out_valid), 32'd0);
      chk("mid.sin",    out_sin, 32'd0);
      chk("mid.orphan", 32'(orphan_err), 32'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
